// File: rtl/multicore_pkg.sv
// Shared core-wide types: datapath width, branch condition codes and
// the branch-resolve control states.
package multicore_pkg;

   localparam int DATA_SIZE = 32;

   // Encodings follow RISC-V funct3 for B-type instructions
   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LT  = 3'b100,
      BR_GE  = 3'b101,
      BR_LTU = 3'b110,
      BR_GEU = 3'b111
   } t_brop;

   typedef enum logic [1:0] {
      ACCEPT,
      REDIRECT,
      FLUSH
   } t_bru_state;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake and data bundle between the execute stage, fetch and the
// branch resolve unit.
interface branch_resolve_unit_if
   import multicore_pkg::*;
#(
   parameter int CNT_W = 32
) ();

   logic                        i_valid;
   logic                        o_ready;
   logic                        i_is_branch;
   logic                        i_is_jal;
   logic                        i_is_jalr;
   t_brop                       i_funct;
   logic signed [DATA_SIZE-1:0] i_rs1;
   logic signed [DATA_SIZE-1:0] i_rs2;
   logic        [DATA_SIZE-1:0] i_pc;
   logic        [DATA_SIZE-1:0] i_imm;
   logic                        i_pred_taken;
   logic                        o_resolved;
   logic                        o_taken;
   logic        [DATA_SIZE-1:0] o_link_data;
   logic                        o_redirect_valid;
   logic        [DATA_SIZE-1:0] o_redirect_pc;
   logic                        i_redirect_ready;
   logic                        o_flush;
   logic                        o_misalign;
   logic        [CNT_W-1:0]     o_mispredict_count;

   modport slave (
      input  i_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct,
             i_rs1, i_rs2, i_pc, i_imm, i_pred_taken, i_redirect_ready,
      output o_ready, o_resolved, o_taken, o_link_data, o_redirect_valid,
             o_redirect_pc, o_flush, o_misalign, o_mispredict_count
   );

   modport master (
      output i_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct,
             i_rs1, i_rs2, i_pc, i_imm, i_pred_taken, i_redirect_ready,
      input  o_ready, o_resolved, o_taken, o_link_data, o_redirect_valid,
             o_redirect_pc, o_flush, o_misalign, o_mispredict_count
   );

endinterface

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator; unknown conditions report false.
module branch_compare
   import multicore_pkg::*;
(
   input  t_brop                       i_funct,
   input  logic signed [DATA_SIZE-1:0] i_rs1,
   input  logic signed [DATA_SIZE-1:0] i_rs2,
   output logic                        o_cmp
);

   always_comb begin
      o_cmp = 1'b0;
      case (i_funct)
         BR_EQ:   o_cmp = (i_rs1 == i_rs2);
         BR_NE:   o_cmp = (i_rs1 != i_rs2);
         BR_LT:   o_cmp = (i_rs1 <  i_rs2);
         BR_GE:   o_cmp = (i_rs1 >= i_rs2);
         BR_LTU:  o_cmp = ($unsigned(i_rs1) <  $unsigned(i_rs2));
         BR_GEU:  o_cmp = ($unsigned(i_rs1) >= $unsigned(i_rs2));
         default: o_cmp = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: decides taken/not-taken, checks the fetch
// prediction, redirects fetch and holds a flush window on a mispredict.
module branch_resolve_unit
   import multicore_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   branch_resolve_unit_if.slave bus
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   t_bru_state           state_p1;
   logic [FC_W-1:0]      flush_cnt_p1;
   logic                 resolved_p1;
   logic                 taken_p1;
   logic [DATA_SIZE-1:0] link_p1;
   logic                 redirect_vld_p1;
   logic [DATA_SIZE-1:0] redirect_pc_p1;
   logic                 flush_p1;
   logic                 misalign_p1;
   logic [CNT_W-1:0]     mispredict_cnt_p1;

   logic                 cmp_p0;
   logic                 vld_p0;
   logic                 is_jalr_p0;
   logic                 is_jal_p0;
   logic                 is_br_p0;
   logic                 any_p0;
   logic [DATA_SIZE-1:0] jalr_sum_p0;
   logic [DATA_SIZE-1:0] target_p0;
   logic [DATA_SIZE-1:0] link_p0;
   logic                 taken_p0;
   logic                 misalign_p0;
   logic                 redirect_p0;
   logic [DATA_SIZE-1:0] redirect_pc_p0;

   branch_compare u_branch_compare (
      .i_funct (bus.i_funct),
      .i_rs1   (bus.i_rs1),
      .i_rs2   (bus.i_rs2),
      .o_cmp   (cmp_p0)
   );

   // Stage p0: decode, target, outcome and redirect decision
   always_comb begin
      vld_p0         = bus.i_valid && (state_p1 == ACCEPT);
      is_jalr_p0     = bus.i_is_jalr;
      is_jal_p0      = bus.i_is_jal && !bus.i_is_jalr;
      is_br_p0       = bus.i_is_branch && !bus.i_is_jal && !bus.i_is_jalr;
      any_p0         = is_jalr_p0 || is_jal_p0 || is_br_p0;
      jalr_sum_p0    = $unsigned(bus.i_rs1) + bus.i_imm;
      target_p0      = is_jalr_p0 ? (jalr_sum_p0 & ~DATA_SIZE'(1))
                                  : (bus.i_pc + bus.i_imm);
      link_p0        = bus.i_pc + DATA_SIZE'(4);
      taken_p0       = is_jalr_p0 || is_jal_p0 || (is_br_p0 && cmp_p0);
      misalign_p0    = taken_p0 && target_p0[1];
      // A misaligned target traps later in the pipe, so it never redirects
      redirect_p0    = any_p0 && !misalign_p0 &&
                       (is_jalr_p0 ||
                        (is_jal_p0 && !bus.i_pred_taken) ||
                        (is_br_p0 && (taken_p0 != bus.i_pred_taken)));
      redirect_pc_p0 = taken_p0 ? target_p0 : link_p0;
   end

   // Stage p1: control FSM and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_p1          <= ACCEPT;
         flush_cnt_p1      <= '0;
         resolved_p1       <= 1'b0;
         taken_p1          <= 1'b0;
         link_p1           <= '0;
         redirect_vld_p1   <= 1'b0;
         redirect_pc_p1    <= '0;
         flush_p1          <= 1'b0;
         misalign_p1       <= 1'b0;
         mispredict_cnt_p1 <= '0;
      end else begin
         resolved_p1 <= 1'b0;
         misalign_p1 <= 1'b0;
         case (state_p1)
            ACCEPT: begin
               if (vld_p0 && any_p0) begin
                  resolved_p1 <= 1'b1;
                  taken_p1    <= taken_p0;
                  link_p1     <= link_p0;
                  misalign_p1 <= misalign_p0;
                  if (redirect_p0) begin
                     state_p1          <= REDIRECT;
                     redirect_vld_p1   <= 1'b1;
                     redirect_pc_p1    <= redirect_pc_p0;
                     flush_p1          <= 1'b1;
                     mispredict_cnt_p1 <= mispredict_cnt_p1 + CNT_W'(1);
                  end
               end
            end
            REDIRECT: begin
               if (bus.i_redirect_ready) begin
                  state_p1        <= FLUSH;
                  redirect_vld_p1 <= 1'b0;
                  flush_cnt_p1    <= FC_W'(FLUSH_CYCLES - 1);
               end
            end
            FLUSH: begin
               if (flush_cnt_p1 == '0) begin
                  state_p1 <= ACCEPT;
                  flush_p1 <= 1'b0;
               end else begin
                  flush_cnt_p1 <= flush_cnt_p1 - FC_W'(1);
               end
            end
            default: state_p1 <= ACCEPT;
         endcase
      end
   end

   assign bus.o_ready            = (state_p1 == ACCEPT);
   assign bus.o_resolved         = resolved_p1;
   assign bus.o_taken            = taken_p1;
   assign bus.o_link_data        = link_p1;
   assign bus.o_redirect_valid   = redirect_vld_p1;
   assign bus.o_redirect_pc      = redirect_pc_p1;
   assign bus.o_flush            = flush_p1;
   assign bus.o_misalign         = misalign_p1;
   assign bus.o_mispredict_count = mispredict_cnt_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus hand-written
// sequences for redirect hold, flush length, back-to-back and reset.
module tb_branch_resolve_unit;
   import multicore_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.CNT_W(32)) bus ();

   branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        br, jal, jalr;
      logic [2:0]  funct;
      logic [31:0] rs1, rs2, pc, imm;
      logic        pred;
      logic        res, tk, rv, mis;
      logic [31:0] rpc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic br, input logic jal, input logic jalr,
                               input logic [2:0] funct, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] pc,
                               input logic [31:0] imm, input logic pred,
                               input logic res, input logic tk, input logic rv,
                               input logic mis, input logic [31:0] rpc);
      vec_t v;
      v.br = br; v.jal = jal; v.jalr = jalr; v.funct = funct;
      v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pred = pred;
      v.res = res; v.tk = tk; v.rv = rv; v.mis = mis; v.rpc = rpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.i_is_branch  = v.br;
      bus.i_is_jal     = v.jal;
      bus.i_is_jalr    = v.jalr;
      bus.i_funct      = t_brop'(v.funct);
      bus.i_rs1        = v.rs1;
      bus.i_rs2        = v.rs2;
      bus.i_pc         = v.pc;
      bus.i_imm        = v.imm;
      bus.i_pred_taken = v.pred;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.o_ready && n < 10) begin
         step();
         n++;
      end
      chk("ready_timeout", {31'd0, bus.o_ready}, 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_resolved"}, {31'd0, bus.o_resolved}, 32'd0);
      chk({tag, "_taken"},    {31'd0, bus.o_taken}, 32'd0);
      chk({tag, "_link"},     bus.o_link_data, 32'd0);
      chk({tag, "_rv"},       {31'd0, bus.o_redirect_valid}, 32'd0);
      chk({tag, "_rpc"},      bus.o_redirect_pc, 32'd0);
      chk({tag, "_flush"},    {31'd0, bus.o_flush}, 32'd0);
      chk({tag, "_misalign"}, {31'd0, bus.o_misalign}, 32'd0);
      chk({tag, "_count"},    bus.o_mispredict_count, 32'd0);
      chk({tag, "_ready"},    {31'd0, bus.o_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t v;
      bus.i_valid = 0; bus.i_redirect_ready = 0;
      bus.i_is_branch = 0; bus.i_is_jal = 0; bus.i_is_jalr = 0;
      bus.i_funct = BR_EQ; bus.i_rs1 = 0; bus.i_rs2 = 0;
      bus.i_pc = 0; bus.i_imm = 0; bus.i_pred_taken = 0;

      //          br jal jalr funct   rs1           rs2           pc            imm           pr  res tk rv mis rpc
      vecs.push_back(mk(1,0,0, 3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       1, 1,1,0,0, 32'h0));
      vecs.push_back(mk(1,0,0, 3'b001, 32'd5,        32'd5,        32'h300,      32'h8,        0, 1,0,0,0, 32'h0));
      vecs.push_back(mk(1,0,0, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h400,      32'h10,       1, 1,0,1,0, 32'h404));
      vecs.push_back(mk(0,0,1, 3'b000, 32'h1001,     32'd0,        32'h500,      32'h4,        1, 1,1,1,0, 32'h1004));
      vecs.push_back(mk(0,0,1, 3'b000, 32'h1002,     32'd0,        32'h600,      32'h0,        1, 1,1,0,1, 32'h0));
      vecs.push_back(mk(0,1,0, 3'b000, 32'd0,        32'd0,        32'h700,      32'h100,      1, 1,1,0,0, 32'h0));
      vecs.push_back(mk(0,1,0, 3'b000, 32'd0,        32'd0,        32'h700,      32'hFFFFFFF8, 0, 1,1,1,0, 32'h6F8));
      vecs.push_back(mk(1,0,0, 3'b101, 32'hFFFFFFFB, 32'd3,        32'h800,      32'h40,       1, 1,0,1,0, 32'h804));
      vecs.push_back(mk(1,0,0, 3'b111, 32'd3,        32'hFFFFFFFB, 32'h840,      32'h40,       0, 1,0,0,0, 32'h0));
      vecs.push_back(mk(1,0,0, 3'b010, 32'd1,        32'd1,        32'h880,      32'h40,       0, 1,0,0,0, 32'h0));
      vecs.push_back(mk(0,0,0, 3'b000, 32'd1,        32'd1,        32'h8C0,      32'h40,       1, 0,0,0,0, 32'h0));
      vecs.push_back(mk(1,1,1, 3'b000, 32'h2000,     32'd7,        32'h900,      32'h10,       1, 1,1,1,0, 32'h2010));
      vecs.push_back(mk(1,0,0, 3'b000, 32'd9,        32'd9,        32'hFFFFFFF0, 32'h20,       0, 1,1,1,0, 32'h10));
      vecs.push_back(mk(1,0,0, 3'b000, 32'd9,        32'd9,        32'h100,      32'h2,        0, 1,1,0,1, 32'h0));

      step(); step();
      chk_all_zero("reset");
      rst = 0;
      step();
      chk_all_zero("post_reset");

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v);
         bus.i_valid = 1;
         step();
         bus.i_valid = 0;
         chk($sformatf("v%0d_resolved", i), {31'd0, bus.o_resolved}, {31'd0, v.res});
         chk($sformatf("v%0d_misalign", i), {31'd0, bus.o_misalign}, {31'd0, v.mis});
         chk($sformatf("v%0d_rv", i), {31'd0, bus.o_redirect_valid}, {31'd0, v.rv});
         chk($sformatf("v%0d_flush", i), {31'd0, bus.o_flush}, {31'd0, v.rv});
         if (v.res) begin
            chk($sformatf("v%0d_taken", i), {31'd0, bus.o_taken}, {31'd0, v.tk});
            chk($sformatf("v%0d_link", i), bus.o_link_data, v.pc + 32'd4);
         end
         if (v.rv) begin
            exp_cnt++;
            chk($sformatf("v%0d_rpc", i), bus.o_redirect_pc, v.rpc);
         end
         chk($sformatf("v%0d_count", i), bus.o_mispredict_count, exp_cnt);
         if (v.rv) begin
            bus.i_redirect_ready = 1;
            step();
            bus.i_redirect_ready = 0;
            chk($sformatf("v%0d_rv_drop", i), {31'd0, bus.o_redirect_valid}, 32'd0);
            wait_ready();
         end else begin
            chk($sformatf("v%0d_ready", i), {31'd0, bus.o_ready}, 32'd1);
         end
         step();
      end

      // BLT mispredict with a stalled fetch, then exact flush length
      drive(mk(1,0,0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 0, 0,0,0,0, 32'h0));
      bus.i_valid = 1;
      step();
      exp_cnt++;
      chk("blt_rv", {31'd0, bus.o_redirect_valid}, 32'd1);
      chk("blt_rpc", bus.o_redirect_pc, 32'h240);
      chk("blt_flush", {31'd0, bus.o_flush}, 32'd1);
      chk("blt_taken", {31'd0, bus.o_taken}, 32'd1);
      chk("blt_count", bus.o_mispredict_count, exp_cnt);
      drive(mk(0,1,0, 3'b000, 32'd0, 32'd0, 32'h300, 32'h100, 0, 0,0,0,0, 32'h0));
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("hold%0d_rv", k), {31'd0, bus.o_redirect_valid}, 32'd1);
         chk($sformatf("hold%0d_rpc", k), bus.o_redirect_pc, 32'h240);
         chk($sformatf("hold%0d_ready", k), {31'd0, bus.o_ready}, 32'd0);
         chk($sformatf("hold%0d_resolved", k), {31'd0, bus.o_resolved}, 32'd0);
         chk($sformatf("hold%0d_count", k), bus.o_mispredict_count, exp_cnt);
      end
      bus.i_valid = 0;
      bus.i_redirect_ready = 1;
      step();
      bus.i_redirect_ready = 0;
      chk("fl1_rv", {31'd0, bus.o_redirect_valid}, 32'd0);
      chk("fl1_flush", {31'd0, bus.o_flush}, 32'd1);
      chk("fl1_ready", {31'd0, bus.o_ready}, 32'd0);
      step();
      chk("fl2_flush", {31'd0, bus.o_flush}, 32'd1);
      chk("fl2_ready", {31'd0, bus.o_ready}, 32'd0);
      step();
      chk("fl3_flush", {31'd0, bus.o_flush}, 32'd0);
      chk("fl3_ready", {31'd0, bus.o_ready}, 32'd1);
      chk("fl3_count", bus.o_mispredict_count, exp_cnt);

      // Four correctly predicted transfers on consecutive cycles; a stray
      // redirect-ready while accepting must be ignored
      bus.i_redirect_ready = 1;
      bus.i_valid = 1;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: drive(mk(1,0,0, 3'b000, 32'd4, 32'd4, 32'h1000, 32'h10, 1, 0,0,0,0, 32'h0));
            1: drive(mk(1,0,0, 3'b001, 32'd4, 32'd4, 32'h1004, 32'h10, 0, 0,0,0,0, 32'h0));
            2: drive(mk(1,0,0, 3'b100, 32'd1, 32'd2, 32'h1008, 32'h10, 1, 0,0,0,0, 32'h0));
            default: drive(mk(0,1,0, 3'b000, 32'd0, 32'd0, 32'h100C, 32'h20, 1, 0,0,0,0, 32'h0));
         endcase
         step();
         chk($sformatf("b2b%0d_resolved", k), {31'd0, bus.o_resolved}, 32'd1);
         chk($sformatf("b2b%0d_ready", k), {31'd0, bus.o_ready}, 32'd1);
         chk($sformatf("b2b%0d_link", k), bus.o_link_data, 32'h1004 + 32'(4 * k));
         chk($sformatf("b2b%0d_rv", k), {31'd0, bus.o_redirect_valid}, 32'd0);
      end
      bus.i_valid = 0;
      bus.i_redirect_ready = 0;
      step();
      chk("b2b_idle_resolved", {31'd0, bus.o_resolved}, 32'd0);
      chk("b2b_count", bus.o_mispredict_count, exp_cnt);

      // Reset in the middle of a pending redirect
      drive(mk(0,0,1, 3'b000, 32'h3000, 32'd0, 32'h40, 32'h8, 1, 0,0,0,0, 32'h0));
      bus.i_valid = 1;
      step();
      bus.i_valid = 0;
      chk("pre_rst_rv", {31'd0, bus.o_redirect_valid}, 32'd1);
      chk("pre_rst_rpc", bus.o_redirect_pc, 32'h3008);
      step();
      rst = 1;
      step();
      rst = 0;
      chk_all_zero("mid_redirect_reset");
      step();
      chk_all_zero("after_reset_release");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
